seq_divider_6by3: RTL and testbench

Sequential restoring divider: 6-bit unsigned dividend by 3-bit unsigned divisor, giving a 6-bit quotient and a 3-bit remainder. It is the inverse companion of the 3×3 array multiplier: a multiplier product (6 bits) fed back with one of its factors returns the other factor. It uses one subtract/compare step per clock, with a start/busy/done handshake. It sits beside the adder/multiplier datapath behind the same top-level pin mux.

---
 rtl/seq_divider_6by3_pkg.sv | 23 ++
 rtl/seq_divider_6by3_div_step.sv | 28 ++
 rtl/seq_divider_6by3.sv | 110 +++++++++++
 tb/tb_seq_divider_6by3.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_6by3_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package div_pkg;

  // Default operand widths: dividend/quotient and divisor/remainder.
  localparam int DIV_DIVIDEND_W = 6;
  localparam int DIV_DIVISOR_W  = 3;

  // One subtract/compare step per dividend bit.
  localparam int DIV_STEPS = DIV_DIVIDEND_W;

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_DIVIDEND_W-1:0] DIV_Q_DBZ = '1;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider_6by3_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract divisor.
// Latency: combinational, no registers.
// Backpressure: none; evaluated every cycle, consumed only while running.
module div_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DIV_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   i_pr,
  input  logic                 i_bit,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic [DIVISOR_W:0]   o_pr,
  output logic                 o_q_bit
);

  // The incoming partial remainder is always < divisor, so its top bit is
  // zero in practice; it is kept in the widened compare so every bit is used.
  logic [DIVISOR_W+1:0] w_ext;
  logic [DIVISOR_W+1:0] w_dvs;

  assign w_ext   = {i_pr, i_bit};
  assign w_dvs   = {2'b00, i_divisor};
  assign o_q_bit = (w_ext >= w_dvs);
  // After a successful subtract the result is < divisor, and without one the
  // shifted value is < 2*divisor, so DIVISOR_W+1 bits always suffice.
  assign o_pr    = (DIVISOR_W+1)'(o_q_bit ? (w_ext - w_dvs) : w_ext);

endmodule

// File: rtl/seq_divider_6by3.sv
// Sequential 6/3-bit unsigned restoring divider with start/busy/done handshake.
// Latency: 7 cycles from accepted start to done; divide-by-zero takes 1 cycle.
// Backpressure: start is ignored while busy; it is accepted in IDLE or DONE.
module seq_divider_6by3
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W     = $clog2(DIVIDEND_W);
  localparam int LAST_STEP = DIVIDEND_W - 1;

  div_state_t            r_state;
  logic [DIVIDEND_W-1:0] r_q;     // dividend shifts out of the top, quotient bits in at the bottom
  logic [DIVISOR_W:0]    r_pr;    // partial remainder, one guard bit wider than the divisor
  logic [DIVISOR_W-1:0]  r_dvsr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_dbz;

  logic [DIVISOR_W:0]    w_pr_nxt;
  logic                  w_q_bit;

  // Single step datapath shared by every RUN cycle.
  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .i_pr      (r_pr),
    .i_bit     (r_q[DIVIDEND_W-1]),
    .i_divisor (r_dvsr),
    .o_pr      (w_pr_nxt),
    .o_q_bit   (w_q_bit)
  );

  // FSM, step counter and operand/result registers; DONE accepts a new start
  // just like IDLE so back-to-back divisions lose no cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_pr    <= '0;
      r_dvsr  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_busy <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_q     <= '1;
              r_pr    <= '0;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_q     <= dividend;
              r_dvsr  <= divisor;
              r_pr    <= '0;
              r_cnt   <= '0;
              r_dbz   <= 1'b0;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_q   <= {r_q[DIVIDEND_W-2:0], w_q_bit};
          r_pr  <= w_pr_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(LAST_STEP)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_q;
  // Final remainder is < divisor, so the guard bit is always zero here.
  assign remainder   = r_pr[DIVISOR_W-1:0];
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider_6by3.sv
// Directed and exhaustive checks for the sequential 6/3-bit divider.
// Latency: drives one division at a time, samples 1ns after each rising edge.
// Backpressure: exercises start-while-busy, back-to-back starts and mid-run reset.
module tb_seq_divider_6by3;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] dividend;
  logic [2:0] divisor;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [2:0] remainder;
  logic       div_by_zero;

  int n_cmp;
  int n_err;

  seq_divider_6by3 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launch one division from an idle state and follow it to done.
  // inj_at > 0 pulses a competing 9/2 start in that busy cycle.
  task automatic do_div(input string tag, input int dvd, input int dvs, input int inj_at,
                        input int exp_q, input int exp_r, input int exp_z,
                        input int exp_lat, input int exp_busy);
    int lat;
    int bcnt;
    lat  = 0;
    bcnt = 0;
    start    = 1'b1;
    dividend = 6'(dvd);
    divisor  = 3'(dvs);
    tick();
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (busy) bcnt++;
      if (n == inj_at) begin
        start    = 1'b1;
        dividend = 6'd9;
        divisor  = 3'd2;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, ":latency"}, lat, exp_lat);
    chk({tag, ":busy_cycles"}, bcnt, exp_busy);
    chk({tag, ":busy_at_done"}, int'(busy), 0);
    chk({tag, ":quotient"}, int'(quotient), exp_q);
    chk({tag, ":remainder"}, int'(remainder), exp_r);
    chk({tag, ":div_by_zero"}, int'(div_by_zero), exp_z);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat1;
    int lat2;
    int seen;
    int eq;
    int er;
    int ez;
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    repeat (3) tick();
    chk("reset:busy", int'(busy), 0);
    chk("reset:done", int'(done), 0);
    chk("reset:quotient", int'(quotient), 0);
    chk("reset:remainder", int'(remainder), 0);
    chk("reset:dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    tick();
    chk("idle:busy", int'(busy), 0);

    // Basic division, then confirm results hold and done is a single pulse.
    do_div("45/6", 45, 6, 0, 7, 3, 0, 7, 6);
    tick();
    chk("45/6:done_pulse", int'(done), 0);
    chk("45/6:hold_q", int'(quotient), 7);
    chk("45/6:hold_r", int'(remainder), 3);

    do_div("63/7", 63, 7, 0, 9, 0, 0, 7, 6);
    do_div("5/7", 5, 7, 0, 0, 5, 0, 7, 6);
    do_div("0/1", 0, 1, 0, 0, 0, 0, 7, 6);
    do_div("10/0", 10, 0, 0, 63, 0, 1, 1, 0);
    tick();
    do_div("40/5_inj", 40, 5, 3, 8, 0, 0, 7, 6);

    // Start held high: second operands accepted in the first DONE cycle.
    tick();
    lat1     = 0;
    lat2     = 0;
    start    = 1'b1;
    dividend = 6'd42;
    divisor  = 3'd6;
    tick();
    dividend = 6'd30;
    divisor  = 3'd4;
    for (int n = 1; n <= 30; n++) begin
      if (done) begin
        if (lat1 == 0) begin
          lat1 = n;
          chk("b2b:q1", int'(quotient), 7);
          chk("b2b:r1", int'(remainder), 0);
        end else begin
          lat2 = n;
          chk("b2b:q2", int'(quotient), 7);
          chk("b2b:r2", int'(remainder), 2);
          break;
        end
      end
      if (lat1 != 0 && n == lat1 + 1) begin
        chk("b2b:busy_after_reaccept", int'(busy), 1);
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("b2b:lat1", lat1, 7);
    chk("b2b:lat2", lat2, 14);

    // Reset in the third busy cycle aborts with no done pulse.
    tick();
    start    = 1'b1;
    dividend = 6'd50;
    divisor  = 3'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst:busy", int'(busy), 0);
    chk("rst:done", int'(done), 0);
    chk("rst:quotient", int'(quotient), 0);
    chk("rst:remainder", int'(remainder), 0);
    chk("rst:dbz", int'(div_by_zero), 0);
    seen = 0;
    repeat (10) begin
      if (done || busy) seen = 1;
      tick();
    end
    chk("rst:no_done", seen, 0);
    do_div("50/3", 50, 3, 0, 16, 2, 0, 7, 6);

    // Every operand pair against the reference quotient/remainder.
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 8; b++) begin
        if (b == 0) begin
          eq = 63;
          er = 0;
          ez = 1;
        end else begin
          eq = a / b;
          er = a % b;
          ez = 0;
        end
        do_div($sformatf("sweep_%0d/%0d", a, b), a, b, 0, eq, er, ez,
               (b == 0) ? 1 : 7, (b == 0) ? 0 : 6);
        if (b != 0) chk($sformatf("sweep_%0d/%0d:identity", a, b),
                        int'(quotient) * b + int'(remainder), a);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
